data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
Parametrised successor to the single-cycle data memory. It is a byte-addressed RISC-V load/store memory with a valid/ready request port and a registered one-cycle response. It supports byte-lane writes, sign/zero-extended loads of sub-word sizes, and flags misaligned or out-of-range accesses. After reset it runs a sequential clear of the array before accepting requests. It sits between the core's MEM stage and the local data array.

Parameters:
XLEN, 32, data width in bits; legal values 32 or 64; elaboration error otherwise.
DEPTH, 256, number of XLEN-wide words; power of two, at least 2.
ADDR_W, 32, byte-address width of req_addr.
INIT_CLEAR, 1, 1 = zero the array after reset; 0 = skip straight to RUN.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RISC-V funct3 size/sign code.
req_addr  in  ADDR_W  byte address.
req_wdata  in  XLEN  store data, LSB-aligned.
rsp_valid  out  1  one-cycle pulse, response for the accepted request.
rsp_rdata  out  XLEN  load result, extended; 0 for stores and errors.
rsp_err  out  1  accepted request was misaligned, out of range or illegal.
init_done  out  1  high once the clear sequence has finished.

Behaviour:
- Reset (async, rst=1): state=CLEAR (or RUN if INIT_CLEAR=0).
  - Outputs: clr_idx=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0 (1 if INIT_CLEAR=0).
  - Array contents are not reset directly.
- CLEAR state:
  - Each cycle, word[clr_idx] is set to 0 and clr_idx is incremented.
  - When clr_idx==DEPTH-1 is written, the next state is RUN and init_done goes to 1.
  - CLEAR lasts exactly DEPTH cycles after rst deasserts.
  - Requests are ignored and req_ready is 0.
  - rst asserted mid-clear restarts the sequence from 0.
- RUN state:
  - req_ready=1 combinationally.
  - A request is accepted on any edge with req_valid & req_ready; back-to-back acceptance every cycle is allowed.
- Latency: a request accepted at edge N produces rsp_valid=1 with rsp_rdata/rsp_err during cycle N+1 (after edge N). rsp_valid is 0 in every other cycle.
- Address split:
  - Byte offset = req_addr[OFF-1:0], where OFF = log2(XLEN/8).
  - Word index = req_addr[ADDR_W-1:OFF].
- funct3 decode:
  - 000 = B, 001 = H, 010 = W (all signed for loads).
  - 100 = BU, 101 = HU.
  - 011 = D and 110 = WU, legal only when XLEN=64.
  - Stores accept only 000, 001, 010 (plus 011 at XLEN=64).
- Error conditions, any of which sets rsp_err=1:
  - Offset not a multiple of the access size.
  - Word index ≥ DEPTH.
  - Illegal funct3 for the given req_we/XLEN.
- On an error: no array write, rsp_rdata=0.
- Stores:
  - Data is shifted to the byte lanes selected by the offset.
  - Only the enabled lanes of the word are written at the accept edge; all other lanes are untouched.
  - rsp_rdata=0, rsp_err=0 on success.
- Loads:
  - The selected lanes are extracted and shifted to the LSB.
  - Signed codes sign-extend from the access MSB; U codes zero-extend.
- Ordering:
  - A store accepted at edge N followed by a load of the same word at edge N+1 returns the post-store data.
  - A load in the same cycle as no store returns current contents.
- Widths: all lane masks are XLEN/8 bits; extension is arithmetic to XLEN; no truncation of req_addr beyond the index range check.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU).
  - State enum {CLEAR, RUN}.
  - Function size_bytes(funct3).
- Sub-module dmem_align (combinational):
  - Inputs funct3, offset, wdata, raw read word.
  - Outputs byte-enable mask, aligned write word, extended load data and misaligned flag.
- data_memory holds the FSM, clear counter, array and response registers.

Test Plan:
- Reset then idle, DEPTH=16, INIT_CLEAR=1 -> req_ready=0 for 16 cycles, then init_done=1 and req_ready=1; LW at 0x0 returns 0x00000000.
- SW 0xDEADBEEF @0x4; LB @0x7; LBU @0x7; LH @0x4; LHU @0x6 -> 0xFFFFFFDE, 0x000000DE, 0xFFFFBEEF, 0x0000DEAD, each with rsp_valid exactly one cycle after accept.
- SW 0x11223344 @0x8; SB 0xAA @0x9; LW @0x8 on the very next cycle -> 0x1122AA44 (lane merge and write-then-read ordering).
- LH @0x3; SW @0x6; LW @(DEPTH*4) -> rsp_err=1, rsp_rdata=0; a following LW @0x4 shows unchanged memory.
- XLEN=64: SD 0x8000000000000001 @0x8; LWU @0xC; LW @0xC; LD @0x8 -> 0x0000000080000000, 0xFFFFFFFF80000000, original value; funct3=011 at XLEN=32 -> rsp_err=1.
- Assert rst for 1 cycle at clear index 5 -> restart; init_done rises exactly DEPTH cycles after rst deasserts; rsp_valid stays 0 throughout.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory: funct3 size/sign codes,
// controller states and the access-size helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Access size in bytes for a funct3 code; 0 marks a code with no size.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        logic [3:0] size;
        case (funct3)
            F3_B, F3_BU: size = 4'd1;
            F3_H, F3_HU: size = 4'd2;
            F3_W, F3_WU: size = 4'd4;
            F3_D:        size = 4'd8;
            default:     size = 4'd0;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for the data memory: builds the store byte-enable
// mask and lane-aligned store word, extracts and extends load data, and
// flags offsets that are not a multiple of the access size.
module dmem_align
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                 funct3_i,
    input  logic [$clog2(XLEN/8)-1:0]  offset_i,
    input  logic [XLEN-1:0]            wdata_i,
    input  logic [XLEN-1:0]            rdata_i,
    output logic [XLEN/8-1:0]          be_o,
    output logic [XLEN-1:0]            wdata_o,
    output logic [XLEN-1:0]            load_o,
    output logic                       misaligned_o
);

    localparam int NB = XLEN / 8;

    logic [3:0]              size_s;
    logic [3:0]              off_s;
    logic [NB-1:0]           base_mask_s;
    logic [$clog2(XLEN)-1:0] shamt_s;
    logic [XLEN-1:0]         shifted_s;

    assign size_s    = size_bytes(funct3_i);
    assign off_s     = 4'(offset_i);
    assign shamt_s   = {offset_i, 3'b000};
    assign shifted_s = rdata_i >> shamt_s;
    assign wdata_o   = wdata_i << shamt_s;
    assign be_o      = base_mask_s << offset_i;

    // Lane mask for the access size before it is moved to the byte offset.
    always_comb begin
        base_mask_s = {NB{1'b0}};
        case (size_s)
            4'd1:    base_mask_s = NB'(8'h01);
            4'd2:    base_mask_s = NB'(8'h03);
            4'd4:    base_mask_s = NB'(8'h0F);
            4'd8:    base_mask_s = NB'(8'hFF);
            default: base_mask_s = {NB{1'b0}};
        endcase
    end

    // Offset must be a multiple of the size; sizeless codes are reported as illegal elsewhere.
    always_comb begin
        misaligned_o = 1'b0;
        if (size_s != 4'd0) begin
            misaligned_o = ((off_s & (size_s - 4'd1)) != 4'd0);
        end else begin
            misaligned_o = 1'b0;
        end
    end

    // Move the addressed lanes to the LSB and extend to the full width.
    always_comb begin
        load_o = {XLEN{1'b0}};
        case (funct3_i)
            F3_B:    load_o = XLEN'($signed(shifted_s[7:0]));
            F3_H:    load_o = XLEN'($signed(shifted_s[15:0]));
            F3_W:    load_o = XLEN'($signed(shifted_s[31:0]));
            F3_D:    load_o = shifted_s;
            F3_BU:   load_o = XLEN'(shifted_s[7:0]);
            F3_HU:   load_o = XLEN'(shifted_s[15:0]);
            F3_WU:   load_o = XLEN'(shifted_s[31:0]);
            default: load_o = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed RISC-V load/store data memory with a valid/ready request
// port and a registered one-cycle response. After reset the array is
// swept to zero one word per cycle before requests are accepted.
module data_memory
    import dmem_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 32,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int NB    = XLEN / 8;
    localparam int OFF   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int IW    = ADDR_W - OFF;
    localparam state_e RESET_STATE = (INIT_CLEAR != 0) ? CLEAR : RUN;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("data_memory: XLEN must be 32 or 64");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("data_memory: DEPTH must be a power of two, at least 2");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
    logic [XLEN-1:0]    mem_q [DEPTH];

    logic [OFF-1:0]     offset_s;
    logic [IW-1:0]      widx_s;
    logic [IDX_W-1:0]   idx_s;
    logic [NB-1:0]      be_s;
    logic [XLEN-1:0]    wdata_al_s;
    logic [XLEN-1:0]    rdata_raw_s;
    logic [XLEN-1:0]    load_s;
    logic               misaligned_s;
    logic               oor_s;
    logic               illegal_s;
    logic               err_s;
    logic               accept_s;
    logic               clr_we_s;
    logic               st_we_s;

    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [XLEN-1:0]    rsp_rdata_q, rsp_rdata_d;

    assign offset_s    = req_addr[OFF-1:0];
    assign widx_s      = req_addr[ADDR_W-1:OFF];
    assign idx_s       = widx_s[IDX_W-1:0];
    assign oor_s       = (64'(widx_s) >= 64'(DEPTH));
    assign rdata_raw_s = mem_q[idx_s];
    assign err_s       = misaligned_s | oor_s | illegal_s;

    // Ready is held low while reset is applied, even when no clear is configured.
    assign req_ready   = (state_q == RUN) && !rst;
    assign accept_s    = req_valid && req_ready;
    assign clr_we_s    = (state_q == CLEAR) && !rst;
    assign st_we_s     = accept_s && req_we && !err_s;
    assign init_done   = (state_q == RUN);

    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;

    dmem_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3_i     (req_funct3),
        .offset_i     (offset_s),
        .wdata_i      (req_wdata),
        .rdata_i      (rdata_raw_s),
        .be_o         (be_s),
        .wdata_o      (wdata_al_s),
        .load_o       (load_s),
        .misaligned_o (misaligned_s)
    );

    // Legal funct3 codes differ between loads and stores and depend on XLEN.
    always_comb begin
        illegal_s = 1'b1;
        if (req_we) begin
            case (req_funct3)
                F3_B, F3_H, F3_W: illegal_s = 1'b0;
                F3_D:             illegal_s = (XLEN != 64);
                default:          illegal_s = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal_s = 1'b0;
                F3_D, F3_WU:                    illegal_s = (XLEN != 64);
                default:                        illegal_s = 1'b1;
            endcase
        end
    end

    // Controller next state: sweep every index once, then stay in RUN.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + IDX_W'(1);
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end else begin
                    state_d = CLEAR;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = RESET_STATE;
        endcase
    end

    // Response contents for the request accepted on this edge.
    always_comb begin
        rsp_valid_d = accept_s;
        rsp_err_d   = accept_s && err_s;
        if (accept_s && !err_s && !req_we) begin
            rsp_rdata_d = load_s;
        end else begin
            rsp_rdata_d = {XLEN{1'b0}};
        end
    end

    // Controller state and clear index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            clr_idx_q <= {IDX_W{1'b0}};
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Registered response port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= {XLEN{1'b0}};
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Array write port: zero sweep during CLEAR, lane-masked stores in RUN.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_q[clr_idx_q] <= {XLEN{1'b0}};
        end else if (st_we_s) begin
            for (int b = 0; b < NB; b++) begin
                if (be_s[b]) begin
                    mem_q[idx_s][b*8 +: 8] <= wdata_al_s[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: one XLEN=32 and one XLEN=64 instance,
// both DEPTH=16 with the clear sweep enabled.
module tb_data_memory;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_valid, a_ready, a_we, a_rsp_valid, a_err, a_done;
    logic [2:0]  a_f3;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_valid, b_ready, b_we, b_rsp_valid, b_err, b_done;
    logic [2:0]  b_f3;
    logic [31:0] b_addr;
    logic [63:0] b_wdata, b_rdata;

    data_memory #(.XLEN(32), .DEPTH(DEPTH), .ADDR_W(32), .INIT_CLEAR(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_funct3(a_f3), .req_addr(a_addr), .req_wdata(a_wdata), .rsp_valid(a_rsp_valid),
        .rsp_rdata(a_rdata), .rsp_err(a_err), .init_done(a_done));

    data_memory #(.XLEN(64), .DEPTH(DEPTH), .ADDR_W(32), .INIT_CLEAR(1)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_funct3(b_f3), .req_addr(b_addr), .req_wdata(b_wdata), .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rdata), .rsp_err(b_err), .init_done(b_done));

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard for instance A: every response must match the oldest expectation.
    always @(negedge clk) begin
        if (a_rsp_valid === 1'b1) begin
            if (q_a.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_unexpected_rsp: got rsp_valid=1 rdata=%h, expected no response", a_rdata);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check({e.name, "_rdata"}, {32'd0, a_rdata}, e.data);
                check({e.name, "_err"}, 64'(a_err), 64'(e.err));
                check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        if (b_rsp_valid === 1'b1) begin
            if (q_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected_rsp: got rsp_valid=1 rdata=%h, expected no response", b_rdata);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check({e.name, "_rdata"}, b_rdata, e.data);
                check({e.name, "_err"}, 64'(b_err), 64'(e.err));
                check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Drive one request for one cycle (called #1 after a rising edge) and push its expectation.
    task automatic issue(input bit sel, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [63:0] exp_d, input logic exp_e,
                         input string nm);
        exp_t e;
        if (!sel) begin
            a_valid = 1'b1; a_we = we; a_f3 = f3; a_addr = addr; a_wdata = wd[31:0];
            b_valid = 1'b0;
            check({nm, "_ready"}, 64'(a_ready), 64'd1);
        end else begin
            b_valid = 1'b1; b_we = we; b_f3 = f3; b_addr = addr; b_wdata = wd;
            a_valid = 1'b0;
            check({nm, "_ready"}, 64'(b_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        e.data = exp_d;
        e.err  = exp_e;
        e.cyc  = cyc;
        e.name = nm;
        if (!sel) q_a.push_back(e);
        else      q_b.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        rst = 1'b1;
        a_valid = 1'b0; a_we = 1'b0; a_f3 = 3'd0; a_addr = 32'd0; a_wdata = 32'd0;
        b_valid = 1'b0; b_we = 1'b0; b_f3 = 3'd0; b_addr = 32'd0; b_wdata = 64'd0;

        @(negedge clk);
        check("reset_outputs_a", {a_ready, a_done, a_rsp_valid, a_err, 28'd0, a_rdata}, 64'd0);
        check("reset_outputs_b", {60'd0, b_ready, b_done, b_rsp_valid, b_err}, 64'd0);
        check("reset_rdata_b", b_rdata, 64'd0);

        // Start a sweep, then re-assert reset at clear index 5 to force a restart.
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (a_ready !== 1'b0 || a_done !== 1'b0 || b_ready !== 1'b0 || b_done !== 1'b0 ||
                a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) bad++;
        end
        check("clear_window_idle_cycles", 64'(bad), 64'd0);
        @(negedge clk);
        check("init_done_a", 64'(a_done), 64'd1);
        check("req_ready_a", 64'(a_ready), 64'd1);
        check("init_done_b", 64'(b_done), 64'd1);
        check("req_ready_b", 64'(b_ready), 64'd1);

        @(posedge clk); #1;
        // XLEN=32 instance
        issue(0, 1'b0, 3'b010, 32'h0, 64'h0, 64'h0, 1'b0, "a_lw0_cleared");
        issue(0, 1'b1, 3'b010, 32'h4, 64'hDEADBEEF, 64'h0, 1'b0, "a_sw4");
        issue(0, 1'b0, 3'b000, 32'h7, 64'h0, 64'hFFFFFFDE, 1'b0, "a_lb7");
        issue(0, 1'b0, 3'b100, 32'h7, 64'h0, 64'h000000DE, 1'b0, "a_lbu7");
        issue(0, 1'b0, 3'b001, 32'h4, 64'h0, 64'hFFFFBEEF, 1'b0, "a_lh4");
        issue(0, 1'b0, 3'b101, 32'h6, 64'h0, 64'h0000DEAD, 1'b0, "a_lhu6");
        issue(0, 1'b1, 3'b010, 32'h8, 64'h11223344, 64'h0, 1'b0, "a_sw8");
        issue(0, 1'b1, 3'b000, 32'h9, 64'hAA, 64'h0, 1'b0, "a_sb9");
        issue(0, 1'b0, 3'b010, 32'h8, 64'h0, 64'h1122AA44, 1'b0, "a_lw8_merge");
        issue(0, 1'b0, 3'b001, 32'h3, 64'h0, 64'h0, 1'b1, "a_lh3_misaligned");
        issue(0, 1'b1, 3'b010, 32'h6, 64'h55555555, 64'h0, 1'b1, "a_sw6_misaligned");
        issue(0, 1'b0, 3'b010, DEPTH * 4, 64'h0, 64'h0, 1'b1, "a_lw_out_of_range");
        issue(0, 1'b0, 3'b010, 32'h4, 64'h0, 64'hDEADBEEF, 1'b0, "a_lw4_unchanged");
        issue(0, 1'b0, 3'b011, 32'h0, 64'h0, 64'h0, 1'b1, "a_ld_illegal");
        issue(0, 1'b1, 3'b100, 32'h0, 64'hFF, 64'h0, 1'b1, "a_sbu_illegal");
        issue(0, 1'b1, 3'b001, 32'hA, 64'h7777, 64'h0, 1'b0, "a_sh_a");
        issue(0, 1'b0, 3'b010, 32'h0, 64'h0, 64'h0, 1'b0, "a_lw0_after_illegal");
        issue(0, 1'b0, 3'b010, 32'h8, 64'h0, 64'h7777AA44, 1'b0, "a_lw8_after_sh");
        // XLEN=64 instance
        issue(1, 1'b0, 3'b011, 32'h0, 64'h0, 64'h0, 1'b0, "b_ld0_cleared");
        issue(1, 1'b1, 3'b011, 32'h8, 64'h8000000000000001, 64'h0, 1'b0, "b_sd8");
        issue(1, 1'b0, 3'b110, 32'hC, 64'h0, 64'h0000000080000000, 1'b0, "b_lwu_c");
        issue(1, 1'b0, 3'b010, 32'hC, 64'h0, 64'hFFFFFFFF80000000, 1'b0, "b_lw_c");
        issue(1, 1'b0, 3'b011, 32'h8, 64'h0, 64'h8000000000000001, 1'b0, "b_ld8");
        issue(1, 1'b0, 3'b011, 32'h4, 64'h0, 64'h0, 1'b1, "b_ld4_misaligned");
        issue(1, 1'b0, 3'b010, DEPTH * 8, 64'h0, 64'h0, 1'b1, "b_lw_out_of_range");
        issue(1, 1'b0, 3'b111, 32'h0, 64'h0, 64'h0, 1'b1, "b_f3_111_illegal");

        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("a_scoreboard_drained", 64'(q_a.size()), 64'd0);
        check("b_scoreboard_drained", 64'(q_b.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
